fetch_unit: RTL

Instruction fetch/issue stage for the 8-bit teaching CPU: reads opcodes from a synchronous program memory, holds them in the instruction register and hands them to the decode stage over a valid/ready handshake. It is the producer of `ir` that the decoder consumes. It owns the program counter, stops on HALT and counts issued instructions.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_pc.sv | 33 +++
 rtl/fetch_unit.sv | 86 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit teaching CPU: opcodes, data width and fetch FSM states.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] OP_NOP   = 8'h00;
  localparam logic [DATA_W-1:0] OP_LOAD3 = 8'h01;
  localparam logic [DATA_W-1:0] OP_ADD9  = 8'h02;
  localparam logic [DATA_W-1:0] OP_HALT  = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StIssue,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Program-memory read port plus the instruction handshake towards decode.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 4
);
  import cpu_pkg::*;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output mem_rd_en,
    output mem_addr,
    output ir,
    output ir_valid,
    input  mem_rdata,
    input  ir_ready
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    input  ir,
    input  ir_valid,
    output mem_rdata,
    output ir_ready
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter: synchronous clear, increment enable, silent wrap on overflow.
module fetch_pc #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch/issue stage: reads opcodes, holds them in ir and hands them to decode via valid/ready.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  fetch_unit_if.master        bus,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic [DATA_W-1:0]   issue_cnt
);

  fetch_state_e      state_d, state_q;
  logic [DATA_W-1:0] ir_d, ir_q;
  logic [DATA_W-1:0] cnt_d, cnt_q;

  logic start_ok;
  logic is_halt;
  logic accept;

  // start only counts when the stage is not busy fetching
  assign start_ok = start && ((state_q == StIdle) || (state_q == StHalt));
  assign is_halt  = (bus.mem_rdata == OP_HALT);
  assign accept   = (state_q == StIssue) && bus.ir_ready;

  fetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (start_ok),
    .inc_i ((state_q == StWait) && !is_halt),
    .pc_o  (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ir_q    <= OP_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StReq;
      StReq:   state_d = StWait;
      StWait:  state_d = is_halt ? StHalt : StIssue;
      StIssue: if (accept) state_d = StReq;
      StHalt:  if (start_ok) state_d = StReq;
      default: state_d = StIdle;
    endcase
  end

  // ir only loads non-HALT opcodes; the count saturates rather than wrapping
  always_comb begin
    ir_d  = ir_q;
    cnt_d = cnt_q;
    if ((state_q == StWait) && !is_halt) begin
      ir_d = bus.mem_rdata;
    end
    if (start_ok) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    bus.mem_rd_en = (state_q == StReq);
    bus.mem_addr  = (state_q == StReq) ? pc : '0;
    bus.ir        = ir_q;
    bus.ir_valid  = (state_q == StIssue);
    halted        = (state_q == StHalt);
    issue_cnt     = cnt_q;
  end

endmodule
